// File: rtl/uart_pkg.sv
// Shared encodings and 8N1 frame constants for the console UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;
    localparam int DEFAULT_CLKS_PER_BIT = 10;

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular receive buffer with extra-MSB pointers; drops a push when full
// unless a pop is accepted in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = DATA_BITS
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic             o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr == {~r_rd_ptr[PW-1], r_rd_ptr[AW-1:0]});
    assign w_do_pop  = i_pop & ~w_empty;
    // A full buffer still takes a push when a pop frees the head slot this cycle.
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_valid = ~w_empty;
    assign o_drop  = i_push & ~w_do_push;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, deframing and a receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rd,
    input  logic                 clr_err,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_ready,
    output logic                 framing_err,
    output logic                 overrun
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam int            IW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx: FIFO_DEPTH must be a power of two >= 2");
    end

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_prev;
    rx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_push;
    logic                 r_framing_err;
    logic                 r_overrun;

    rx_state_t            w_state_nxt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [IW-1:0]        w_idx_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_start;
    logic                 w_push_evt;
    logic                 w_frame_evt;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_valid;
    logic                 w_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // A held-low line (break) never re-triggers: an edge needs a high first.
    assign w_start = ~r_sync2 & r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_push  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_push  <= w_push_evt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_push_evt  = 1'b0;
        w_frame_evt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_start) begin
                    w_state_nxt = ST_START;
                    w_idx_nxt   = '0;
                end
            end
            ST_START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = r_sync2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_sync2, r_shift[DATA_BITS-1:1]};
                    w_idx_nxt   = r_idx + 1'b1;
                    if (r_idx == IDX_LAST) w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                    w_push_evt  = r_sync2;
                    w_frame_evt = ~r_sync2;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // r_shift only moves in DATA, so it still holds the byte while r_push is high.
`ifdef UART_RX_FIFO_EN
    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_push      (r_push),
        .i_push_data (r_shift),
        .i_pop       (rd),
        .o_head      (w_head),
        .o_valid     (w_valid),
        .o_drop      (w_drop)
    );
`else
    logic                 r_hold_vld;
    logic [DATA_BITS-1:0] r_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_vld <= 1'b0;
            r_hold     <= '0;
        end else if (r_push && (!r_hold_vld || rd)) begin
            r_hold_vld <= 1'b1;
            r_hold     <= r_shift;
        end else if (rd) begin
            r_hold_vld <= 1'b0;
        end
    end

    assign w_head  = r_hold_vld ? r_hold : '0;
    assign w_valid = r_hold_vld;
    assign w_drop  = r_push & r_hold_vld & ~rd;
`endif

    // An error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_frame_evt)  r_framing_err <= 1'b1;
            else if (clr_err) r_framing_err <= 1'b0;
            if (w_drop)       r_overrun     <= 1'b1;
            else if (clr_err) r_overrun     <= 1'b0;
        end
    end

    assign data        = w_head;
    assign rx_ready    = w_valid;
    assign framing_err = r_framing_err;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: timing, glitch, framing/break, overrun, pop+push, reset.
module tb_uart_rx;
    localparam int CPB    = 10;
    // Negedge count from driving the start bit to the one after the stop sample edge.
    localparam int STOP_K = 3 + CPB / 2 + 9 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data;
    logic       rx_ready;
    logic       framing_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rd          (rd),
        .clr_err     (clr_err),
        .data        (data),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    // Drives one 8N1 frame from a negedge. Optional: timing checks, rd pulse
    // in the stop-sample cycle, early return after abort_k negedges.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit,
                               input bit chk_timing, input bit rd_at_stop, input int abort_k);
        int   k;
        logic v;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      v = 1'b0;
            else if (i == 9) v = stop_bit;
            else             v = b[i-1];
            rx = v;
            for (int j = 0; j < CPB; j++) begin
                @(negedge clk);
                k++;
                if (rd_at_stop) rd = (k == STOP_K - 1);
                if (chk_timing && k == STOP_K) check("ready_before_96", {31'd0, rx_ready}, 32'd0);
                if (chk_timing && k == STOP_K + 1) begin
                    check("ready_at_96", {31'd0, rx_ready}, 32'd1);
                    check("data_at_96", {24'd0, data}, 32'hA5);
                end
                if (k == abort_k) return;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"}, {24'd0, data}, 32'd0);
        check({tag, "_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_ferr"}, {31'd0, framing_err}, 32'd0);
        check({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        wait_n(4);
        check_idle_outputs("reset");
        reset = 1'b0;
        wait_n(5);

        // Single byte with exact ready timing, then pop.
        drive_frame(8'hA5, 1'b1, 1'b1, 1'b0, 0);
        wait_n(2);
        check("a5_ferr", {31'd0, framing_err}, 32'd0);
        check("a5_ovr", {31'd0, overrun}, 32'd0);
        pop();
        check("a5_pop_ready", {31'd0, rx_ready}, 32'd0);

        // Three-cycle glitch must not produce a byte.
        wait_n(5);
        rx = 1'b0;
        wait_n(3);
        rx = 1'b1;
        wait_n(3 * CPB);
        check("glitch_ready", {31'd0, rx_ready}, 32'd0);
        check("glitch_ferr", {31'd0, framing_err}, 32'd0);

        // Low stop bit, then a 50-cycle break, then a clean byte.
        drive_frame(8'h55, 1'b0, 1'b0, 1'b0, 0);
        wait_n(50);
        check("frame_ferr", {31'd0, framing_err}, 32'd1);
        check("frame_ready", {31'd0, rx_ready}, 32'd0);
        rx = 1'b1;
        wait_n(12 * CPB);
        check("break_no_start", {31'd0, rx_ready}, 32'd0);
        clear_errs();
        check("frame_clr", {31'd0, framing_err}, 32'd0);
        drive_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0);
        wait_n(2);
        check("after_break_ready", {31'd0, rx_ready}, 32'd1);
        check("after_break_data", {24'd0, data}, 32'h3C);
        pop();
        wait_n(5);

`ifdef UART_RX_FIFO_EN
        // Nine bytes with no reads: the ninth is dropped.
        for (int i = 1; i <= 9; i++) drive_frame(8'(i), 1'b1, 1'b0, 1'b0, 0);
        wait_n(2);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check("ovr_pop_data", {24'd0, data}, i);
            pop();
        end
        check("ovr_drained", {31'd0, rx_ready}, 32'd0);
        clear_errs();
        check("ovr_clr", {31'd0, overrun}, 32'd0);

        // Full buffer, rd in the stop-sample cycle of the ninth byte.
        for (int i = 0; i < 8; i++) drive_frame(8'h40 + 8'(i), 1'b1, 1'b0, 1'b0, 0);
        drive_frame(8'h48, 1'b1, 1'b0, 1'b1, 0);
        wait_n(2);
        check("sim_ovr", {31'd0, overrun}, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            check("sim_pop_data", {24'd0, data}, 32'h40 + i);
            pop();
        end
        check("sim_drained", {31'd0, rx_ready}, 32'd0);
`else
        // Second byte while holding the first: old kept, new dropped.
        drive_frame(8'h11, 1'b1, 1'b0, 1'b0, 0);
        drive_frame(8'h22, 1'b1, 1'b0, 1'b0, 0);
        wait_n(2);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_data", {24'd0, data}, 32'h11);
        pop();
        check("ovr_drained", {31'd0, rx_ready}, 32'd0);
        clear_errs();
        check("ovr_clr", {31'd0, overrun}, 32'd0);

        // Holding register valid, rd in the stop-sample cycle of the next byte.
        drive_frame(8'h5A, 1'b1, 1'b0, 1'b0, 0);
        drive_frame(8'hA6, 1'b1, 1'b0, 1'b1, 0);
        wait_n(2);
        check("sim_ovr", {31'd0, overrun}, 32'd0);
        check("sim_ready", {31'd0, rx_ready}, 32'd1);
        check("sim_data", {24'd0, data}, 32'hA6);
        pop();
        check("sim_drained", {31'd0, rx_ready}, 32'd0);
`endif

        // Buffered byte plus framing error, then reset during data bit 4.
        wait_n(5);
        drive_frame(8'h77, 1'b1, 1'b0, 1'b0, 0);
        drive_frame(8'h12, 1'b0, 1'b0, 1'b0, 0);
        rx = 1'b1;
        wait_n(2 * CPB);
        check("pre_rst_ready", {31'd0, rx_ready}, 32'd1);
        check("pre_rst_ferr", {31'd0, framing_err}, 32'd1);
        drive_frame(8'hC3, 1'b1, 1'b0, 1'b0, 5 * CPB + CPB / 2);
        reset = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        reset = 1'b0;
        wait_n(3 * CPB);
        check("post_rst_nopush", {31'd0, rx_ready}, 32'd0);
        drive_frame(8'hC3, 1'b1, 1'b0, 1'b0, 0);
        wait_n(2);
        check("post_rst_ready", {31'd0, rx_ready}, 32'd1);
        check("post_rst_data", {24'd0, data}, 32'hC3);
        check("post_rst_ferr", {31'd0, framing_err}, 32'd0);
        pop();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
